fir_mac_seq: RTL
================

Name: fir_mac_seq

Overview:
- Downstream consumer of the `counter` stage's `Read` strobe. Each `Read` pulse marks a new input sample.
- On each strobe the block shifts `Din` into a delay line of NTAPS entries.
- It then runs a single-multiplier multiply-accumulate sequence across all taps.
- It presents the scaled filter output with a one-cycle `Valid` pulse.
- Coefficients come from a small write port driven by the FIR top-level controller.

Parameters:
- DW, 16: input sample width, signed.
- CW, 16: coefficient width, signed.
- NTAPS, 8: number of taps; must be ≥ 2.
- OW, 16: output width, signed.
- SHIFT, 15: right-shift applied to the accumulator before the output slice.
- AW, DW+CW+$clog2(NTAPS): accumulator width. Derived; not overridable.

Ports:
- Clk, input, 1: rising-edge clock.
- Reset_n, input, 1: asynchronous active-low reset.
- Read, input, 1: sample strobe from the upstream stage; acted on only when high at a rising edge in IDLE.
- Din, input, DW: signed sample; sampled on the same edge as an accepted `Read`.
- CoefWr, input, 1: coefficient write enable.
- CoefAddr, input, $clog2(NTAPS): tap index to write.
- CoefIn, input, CW: signed coefficient value.
- Busy, output, 1: high while in MAC or DONE.
- Dout, output, OW: signed filter output; held between results.
- Valid, output, 1: one-cycle pulse when `Dout` updates.
- Overrun, output, 1: one-cycle pulse when `Read` arrives while `Busy`.

Behaviour:
- **Reset** (`Reset_n` low, asynchronous):
  - FSM goes to IDLE.
  - Delay line x[0..NTAPS-1], coefficient bank c[0..NTAPS-1], accumulator and tap index are cleared to 0.
  - `Dout`, `Valid`, `Busy` and `Overrun` go to 0.
  - Reset asserted mid-sequence abandons the sequence; no `Valid` is produced.
- **FSM states:** IDLE, MAC, DONE.
- **IDLE:**
  - If `Read` = 1: x[k] <= x[k-1] for k = 1..NTAPS-1, x[0] <= `Din`, acc <= 0, idx <= 0, next state MAC.
  - Otherwise remain in IDLE.
- **MAC:**
  - Each cycle: acc <= acc + x[idx]*c[idx], as a full-precision signed product sign-extended to AW.
  - idx increments each cycle.
  - After the cycle with idx = NTAPS-1, go to DONE. MAC therefore lasts exactly NTAPS cycles.
- **DONE:**
  - `Dout` <= (acc >>> SHIFT)[OW-1:0], an arithmetic shift with two's-complement wrap.
  - `Valid` = 1 for this one cycle.
  - Next state IDLE.
- **Latency and throughput:**
  - Accepted `Read` at edge T → `Valid` high in the cycle after edge T+NTAPS+1.
  - `Valid` is a registered output, asserted NTAPS+2 edges after acceptance.
  - Minimum strobe spacing is NTAPS+2 cycles.
  - A `Read` received in IDLE the cycle immediately after DONE is accepted.
- **Read while Busy:**
  - The sample is dropped and the delay line is unchanged.
  - `Overrun` pulses high for one cycle.
  - The in-progress result is unaffected.
- **Coefficient writes:**
  - Accepted only when `Busy` = 0; ignored while `Busy` = 1.
  - A write and an accepted `Read` on the same IDLE edge both take effect. The MAC sequence that starts then uses the newly written coefficient.
  - A `CoefAddr` value ≥ NTAPS is ignored.
- `Dout` holds its last value until the next DONE.
- The accumulator cannot overflow within NTAPS terms, given AW.

Optional Feature:
- Macro: FIR_MAC_SAT_EN.
- **Defined:** at DONE, the shifted accumulator is clamped to the OW-bit signed range before the slice.
  - Above 2^(OW-1)-1 → 0x7FFF for OW = 16.
  - Below -2^(OW-1) → 0x8000.
- **Undefined:** plain truncation with two's-complement wrap, as described above.
- Latency is identical in both builds.

Test Plan:
- **Reset mid-sequence:** reset, then release; all outputs 0. Assert `Read`, then pull `Reset_n` low 3 cycles later → `Busy` = 0 immediately, no `Valid`, and a later `Dout` reflects only post-reset samples.
- **Impulse response** (NTAPS = 4, SHIFT = 0, OW = 24): write c = {1, 2, 3, 4}. Strobe `Din` = 1, then 0, 0, 0, 0 at 6-cycle spacing → `Dout` sequence 1, 2, 3, 4, 0, each with a single `Valid` 6 edges after its strobe.
- **Q15 scaling** (defaults): c[0] = 0x4000, others 0; `Din` = 0x2000 → `Dout` = 0x1000 after 10 edges. `Din` = 0xE000 (-8192) → `Dout` = 0xF000.
- **Overrun:** strobe, then assert `Read` again 3 cycles later with `Din` = 0x7FFF → `Overrun` pulses once and the result matches the single-strobe case. The next accepted sample shows 0x7FFF absent from x[1].
- **Coefficient write gating:** `CoefWr` to tap 0 while `Busy` → c[0] unchanged, checked via output. Same-edge `CoefWr` (c[0] = 2) plus `Read` (`Din` = 5) in IDLE, other taps 0, SHIFT = 0 → `Dout` = 10.
- **Saturation** (NTAPS = 4, SHIFT = 0, OW = 16): all c = 0x7FFF, four strobes of 0x7FFF → fourth result 0x7FFF with FIR_MAC_SAT_EN, 0x0004 without.

Source files
------------

// File: rtl/fir_mac_seq.sv
// fir_mac_seq: single-multiplier sequential FIR filter.
// Each accepted Read strobe shifts Din into an NTAPS-deep delay line. The block
// then runs NTAPS multiply-accumulate cycles and presents the scaled result on
// Dout with a one-cycle Valid pulse.
// Build option: define FIR_MAC_SAT_EN to clamp the scaled output to the OW-bit
// signed range instead of wrapping.
module fir_mac_seq #(
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int NTAPS = 8,
  parameter int OW    = 16,
  parameter int SHIFT = 15
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     Read,
  input  logic signed [DW-1:0]     Din,
  input  logic                     CoefWr,
  input  logic [$clog2(NTAPS)-1:0] CoefAddr,
  input  logic signed [CW-1:0]     CoefIn,
  output logic                     Busy,
  output logic signed [OW-1:0]     Dout,
  output logic                     Valid,
  output logic                     Overrun
);

  localparam int IW = $clog2(NTAPS);
  localparam int PW = DW + CW;
  localparam int AW = DW + CW + $clog2(NTAPS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NTAPS - 1);

`ifdef FIR_MAC_SAT_EN
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic signed [DW-1:0] x_q [NTAPS];
  logic signed [DW-1:0] x_d [NTAPS];
  logic signed [CW-1:0] c_q [NTAPS];
  logic signed [CW-1:0] c_d [NTAPS];
  logic signed [AW-1:0] acc_q, acc_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic signed [OW-1:0] dout_q, dout_d;
  logic                 valid_q, valid_d;
  logic                 overrun_q, overrun_d;
  logic signed [PW-1:0] prod;
`ifdef FIR_MAC_SAT_EN
  logic signed [AW-1:0] shifted;
`endif

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> MAC on Read, MAC for NTAPS cycles, DONE for one
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (Read) state_d = ST_MAC;
      ST_MAC:  if (idx_q == LAST_IDX) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode: Busy follows state, the rest are registered
  always_comb begin
    Busy    = (state_q != ST_IDLE);
    Dout    = dout_q;
    Valid   = valid_q;
    Overrun = overrun_q;
  end

  // Datapath next-values: delay line, coefficient bank, MAC and result
  always_comb begin
    x_d       = x_q;
    c_d       = c_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    dout_d    = dout_q;
    valid_d   = 1'b0;
    overrun_d = Read && (state_q != ST_IDLE);
    prod      = PW'(x_q[idx_q]) * PW'(c_q[idx_q]);
`ifdef FIR_MAC_SAT_EN
    shifted   = acc_q >>> SHIFT;
`endif

    // Coefficient port is only open while idle; same-edge Read still sees it
    // because the MAC reads c_q starting one cycle later.
    if ((state_q == ST_IDLE) && CoefWr && (32'(CoefAddr) < 32'(NTAPS))) begin
      c_d[CoefAddr] = CoefIn;
    end

    case (state_q)
      ST_IDLE: begin
        if (Read) begin
          for (int unsigned k = 1; k < NTAPS; k++) begin
            x_d[k] = x_q[k-1];
          end
          x_d[0] = Din;
          acc_d  = '0;
          idx_d  = '0;
        end
      end
      ST_MAC: begin
        acc_d = acc_q + AW'(prod);
        idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      end
      ST_DONE: begin
`ifdef FIR_MAC_SAT_EN
        if (shifted > SAT_MAX) begin
          dout_d = OW'(SAT_MAX);
        end else if (shifted < SAT_MIN) begin
          dout_d = OW'(SAT_MIN);
        end else begin
          dout_d = OW'(shifted);
        end
`else
        dout_d = OW'(acc_q >>> SHIFT);
`endif
        valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned k = 0; k < NTAPS; k++) begin
        x_q[k] <= '0;
        c_q[k] <= '0;
      end
      acc_q     <= '0;
      idx_q     <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      x_q       <= x_d;
      c_q       <= c_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

endmodule
